jtframe_upload: RTL
===================

Name: jtframe_upload

Overview:
- Serves HPS upload requests (NVRAM / high-score save) by reading SDRAM back through the prog_* port. It is the reverse of the ROM download path.
- Sits beside the download logic in the MiSTer top. It sees hps_io ioctl upload signals on one side and the SDRAM controller prog read port on the other.
- Keeps a 4-byte line cache so that sequential byte reads cost one SDRAM access per 32-bit line.

Parameters:
- BASE_ADDR, 22'h0: SDRAM word offset of the upload region.
- SIZE, 1024: region length in bytes. Reads at or beyond SIZE return 8'hFF.
- TIMEOUT, 255: maximum clk_sys cycles to wait for data_rdy before the read is abandoned.

Ports:
- clk_sys  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- ioctl_upload  in  1  level, high while the HPS upload session is active.
- ioctl_rd  in  1  one-cycle strobe requesting the byte at ioctl_addr.
- ioctl_addr  in  23  byte address within the region.
- ioctl_din  out  8  byte returned to hps_io.
- upload_busy  out  1  high while a fetch is outstanding.
- upload_err  out  1  sticky; set on timeout; cleared at the rising edge of ioctl_upload.
- prog_addr  out  22  SDRAM word address.
- prog_rd  out  1  SDRAM read request.
- sdram_ack  in  1  controller accepted the request.
- data_read  in  32  two consecutive SDRAM words.
- data_rdy  in  1  one-cycle strobe; data_read is valid.

Behaviour:
- Reset values:
  - ioctl_din=8'hFF; upload_busy=0; upload_err=0; prog_rd=0; prog_addr=0.
  - Cache invalid; pending=0; state IDLE.
- Address arithmetic:
  - line = ioctl_addr[22:2]; lane = ioctl_addr[1:0].
  - prog_addr = BASE_ADDR + {line,1'b0}, truncated to 22 bits; wrap-around is permitted.
  - Byte lane mapping: lane0=data_read[7:0], lane1=[15:8], lane2=[23:16], lane3=[31:24].
- Request capture:
  - On ioctl_rd with ioctl_upload=1, the address is latched.
  - ioctl_rd is ignored when ioctl_upload=0.
- Hit:
  - Condition: cache valid and tag==line, state IDLE.
  - ioctl_din updates one cycle after ioctl_rd. No SDRAM access; upload_busy stays 0.
- Out of range:
  - Condition: ioctl_addr>=SIZE.
  - ioctl_din=8'hFF one cycle after ioctl_rd. No SDRAM access; cache is untouched.
- Miss, through the state machine:
  - IDLE -> REQ: prog_rd=1, upload_busy=1.
  - REQ -> WAIT on sdram_ack: prog_rd drops in the same cycle sdram_ack is seen.
  - WAIT -> IDLE on data_rdy:
    - cache line stored; tag updated; valid=1.
    - ioctl_din = selected lane, registered the cycle after data_rdy.
    - upload_busy cleared with ioctl_din.
  - Total miss latency = ack latency + data latency + 1 cycle.
- Timeout:
  - An 8-bit counter runs in REQ and WAIT and resets on entry to REQ.
  - Reaching TIMEOUT: prog_rd=0, ioctl_din=8'hFF, upload_err=1, cache invalid, state returns to IDLE.
- Back-to-back requests:
  - ioctl_rd while busy sets pending and latches the new address; a second rd while pending overwrites it (last wins).
  - On return to IDLE, pending is serviced in the next cycle as a fresh rd (hit / miss / range check).
  - ioctl_din reflects the older request for at least one cycle before the pending one completes.
- Session edges:
  - ioctl_upload rising: cache invalidated, upload_err cleared.
  - ioctl_upload falling mid-fetch: abort to IDLE, prog_rd=0, pending=0, cache invalid; ioctl_din holds its last value. A late data_rdy in IDLE is ignored.
- Simultaneous events:
  - data_rdy in the same cycle as timeout expiry: data wins and upload_err is not set.
  - sdram_ack and data_rdy in the same cycle while in REQ: treated as ack then data, completing directly to IDLE.

Decomposition:
- jtframe_upload_pkg:
  - state enum {IDLE, REQ, WAIT};
  - lane-select function;
  - localparam TOCNT_W=8.
- No sub-module; a single flat module with FSM, timeout counter, and cache registers.

Test Plan:
- Hit after miss: upload=1, rd addr 0x000; SDRAM returns 32'hDDCCBBAA after ack+3.
  - din=AA; prog_rd asserted once.
  - Then rd 0x001, 0x002, 0x003 -> BB, CC, DD, each 1 cycle later; prog_rd never re-asserted.
- Line crossing: rd 0x004 with BASE_ADDR=22'h100 -> prog_addr=22'h102; data 32'h44332211 -> din=11.
- Out of range: SIZE=1024, rd 0x400 -> din=FF after 1 cycle; prog_rd stays 0; busy stays 0.
- Timeout: controller never asserts data_rdy.
  - After 255 cycles in REQ/WAIT: din=FF, upload_err=1, prog_rd=0.
  - Next upload rising edge clears upload_err.
- Pending: rd 0x010 (miss), then rd 0x011 two cycles later, while busy.
  - After data_rdy with 32'h87654321: din=21, then the next cycle din=43; exactly one SDRAM read.
- Abort: upload falls while in WAIT -> state IDLE, busy=0.
  - A later data_rdy leaves din unchanged.
  - A new session's rd 0x010 re-fetches from SDRAM.

Source files
------------

// File: rtl/jtframe_upload_pkg.sv
// jtframe_upload_pkg: shared types and helpers for the HPS upload reader.
//   state_t  : fetch state machine (IDLE, REQ, WAIT)
//   TOCNT_W  : width of the fetch timeout counter
//   lane_sel : picks one byte of a 32-bit SDRAM line (lane0 = bits 7:0)
package jtframe_upload_pkg;
   localparam int TOCNT_W = 8;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   function automatic logic [7:0] lane_sel(input logic [31:0] d, input logic [1:0] l);
      return l == 2'd0 ? d[7:0] : l == 2'd1 ? d[15:8] : l == 2'd2 ? d[23:16] : d[31:24];
   endfunction
endpackage

// File: rtl/jtframe_upload.sv
// jtframe_upload: serves hps_io upload byte reads from SDRAM through a 4-byte line cache.
//   clk_sys, rst_n          : clock, asynchronous active-low reset
//   ioctl_upload            : upload session active (level)
//   ioctl_rd, ioctl_addr    : byte read strobe and byte address within the region
//   ioctl_din               : returned byte (8'hFF out of range or on timeout)
//   upload_busy, upload_err : fetch outstanding; sticky timeout flag
//   prog_addr, prog_rd      : SDRAM word address and read request
//   sdram_ack, data_read, data_rdy : controller accept, 32-bit line, data strobe
module jtframe_upload
   import jtframe_upload_pkg::*;
#(
   parameter logic [21:0] BASE_ADDR = 22'h0,
   parameter int          SIZE      = 1024,
   parameter int          TIMEOUT   = 255
)(
   input  logic        clk_sys,
   input  logic        rst_n,
   input  logic        ioctl_upload,
   input  logic        ioctl_rd,
   input  logic [22:0] ioctl_addr,
   output logic [7:0]  ioctl_din,
   output logic        upload_busy,
   output logic        upload_err,
   output logic [21:0] prog_addr,
   output logic        prog_rd,
   input  logic        sdram_ack,
   input  logic [31:0] data_read,
   input  logic        data_rdy
);
   state_t state, state_nx;
   logic [TOCNT_W-1:0] cnt;
   logic [22:0] cur_addr, pend_addr, req_addr;
   logic [31:0] cache;
   logic [20:0] tag;
   logic valid, pend, upload_q;
   logic rd, up_rise, req, in_range, hit, tmo;
   logic start, done, expire, abort;

   assign rd       = ioctl_rd & ioctl_upload;
   assign up_rise  = ioctl_upload & ~upload_q;
   // A queued request is replayed as a fresh read once the FSM is idle; a new strobe is newer and wins.
   assign req      = state == IDLE && ioctl_upload && (ioctl_rd || pend);
   assign req_addr = ioctl_rd ? ioctl_addr : pend_addr;
   assign in_range = {9'd0, req_addr} < SIZE;
   // The rising session edge invalidates the cache in this very cycle, so it must not hit.
   assign hit      = valid && !up_rise && tag == req_addr[22:2];
   assign tmo      = cnt == TOCNT_W'(TIMEOUT - 1);
   assign prog_rd     = state == REQ;
   assign upload_busy = state != IDLE;

   always_ff @(posedge clk_sys or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;

   // Data beats timeout in the same cycle; ack+data together in REQ completes directly.
   always_comb begin
      state_nx = state;
      start    = 1'b0;
      done     = 1'b0;
      expire   = 1'b0;
      abort    = 1'b0;
      case (state)
         IDLE: begin
            start    = req && in_range && !hit;
            state_nx = start ? REQ : IDLE;
         end
         REQ: begin
            abort    = !ioctl_upload;
            done     = ioctl_upload && sdram_ack && data_rdy;
            expire   = ioctl_upload && !done && tmo;
            state_nx = sdram_ack ? WAIT : REQ;
         end
         WAIT: begin
            abort  = !ioctl_upload;
            done   = ioctl_upload && data_rdy;
            expire = ioctl_upload && !data_rdy && tmo;
         end
         default: state_nx = IDLE;
      endcase
      if (abort || done || expire) state_nx = IDLE;
   end

   always_ff @(posedge clk_sys or negedge rst_n)
      if (!rst_n) begin
         ioctl_din  <= 8'hFF;
         upload_err <= 1'b0;
         prog_addr  <= '0;
         cnt        <= '0;
         cur_addr   <= '0;
         pend_addr  <= '0;
         cache      <= '0;
         tag        <= '0;
         valid      <= 1'b0;
         pend       <= 1'b0;
         upload_q   <= 1'b0;
      end else begin
         upload_q <= ioctl_upload;
         cnt      <= start ? '0 : state != IDLE ? cnt + TOCNT_W'(1) : cnt;
         if (up_rise) begin
            valid      <= 1'b0;
            upload_err <= 1'b0;
         end
         if (req) begin
            pend <= 1'b0;
            if (!in_range) ioctl_din <= 8'hFF;
            else if (hit) ioctl_din <= lane_sel(cache, req_addr[1:0]);
            else begin
               cur_addr  <= req_addr;
               prog_addr <= BASE_ADDR + {req_addr[22:2], 1'b0};
            end
         end else if (rd && state != IDLE) begin
            pend      <= 1'b1;
            pend_addr <= ioctl_addr;
         end
         if (done) begin
            cache     <= data_read;
            tag       <= cur_addr[22:2];
            valid     <= 1'b1;
            ioctl_din <= lane_sel(data_read, cur_addr[1:0]);
         end
         if (expire) begin
            ioctl_din  <= 8'hFF;
            upload_err <= 1'b1;
            valid      <= 1'b0;
         end
         if (abort) valid <= 1'b0;
         if (!ioctl_upload) pend <= 1'b0;
      end
endmodule
